// File: rtl/otter_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage OTTER pipeline: keeps a shadow
// scoreboard of EX/MEM/WB and drives stage enables, bubbles, forwarding and perf counters.

// Resolves one DE source operand against the EX/MEM/WB shadow, youngest stage first.
module otter_fwd_unit (
   input  logic        used,
   input  logic [4:0]  rs,
   input  logic [2:0]  stgVld,   // bit 0 = EX, 1 = MEM, 2 = WB
   input  logic [2:0]  stgRw,
   input  logic [14:0] stgRd,
   input  logic [5:0]  stgSel,
   output logic [1:0]  fwdSel,
   output logic        hazard
);
   logic       live;
   logic [2:0] hit;

   always_comb begin
      live = used && (rs != 5'd0);
      for (int s = 0; s < 3; s++)
         hit[s] = live && stgVld[s] && stgRw[s] && (stgRd[5*s +: 5] == rs);
      fwdSel = 2'd0;
      hazard = 1'b0;
      // Only ALU results exist before WB; PC+4, CSR and load data become visible in WB
      if (hit[0]) begin
         if (stgSel[1:0] == 2'd3) fwdSel = 2'd1;
         else                     hazard = 1'b1;
      end else if (hit[1]) begin
         if (stgSel[3:2] == 2'd3) fwdSel = 2'd2;
         else                     hazard = 1'b1;
      end else if (hit[2]) begin
         fwdSel = 2'd3;
      end
   end
endmodule

module otter_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CPU_CLK,
   input  logic             CPU_RST_N,
   input  logic [4:0]       de_rs1,
   input  logic [4:0]       de_rs2,
   input  logic             de_rs1_used,
   input  logic             de_rs2_used,
   input  logic [4:0]       de_rd,
   input  logic             de_reg_write,
   input  logic [1:0]       de_wr_sel,
   input  logic             ex_taken,
   input  logic             mem_busy,
   output logic             pc_we,
   output logic             de_we,
   output logic             ex_bubble,
   output logic             pipe_we,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       rw;
      logic [1:0] sel;
   } stage_t;

   stage_t [2:0] stg;      // [0] = EX, [1] = MEM, [2] = WB
   stage_t       newEx;
   logic         deVld;

   logic [2:0]  stgVld, stgRw;
   logic [14:0] stgRd;
   logic [5:0]  stgSel;
   logic [1:0]  opUsed;
   logic [9:0]  opRs;
   logic [3:0]  opFwd;
   logic [1:0]  opHaz;
   logic        luse, taken, stallInc, flushInc;

   always_comb begin
      for (int s = 0; s < 3; s++) begin
         stgVld[s]         = stg[s].vld;
         stgRw[s]          = stg[s].rw;
         stgRd[5*s +: 5]   = stg[s].rd;
         stgSel[2*s +: 2]  = stg[s].sel;
      end
   end

   assign opUsed = {de_rs2_used, de_rs1_used};
   assign opRs   = {de_rs2, de_rs1};

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : gOp
         otter_fwd_unit uFwd (
            .used   (opUsed[g]),
            .rs     (opRs[5*g +: 5]),
            .stgVld (stgVld),
            .stgRw  (stgRw),
            .stgRd  (stgRd),
            .stgSel (stgSel),
            .fwdSel (opFwd[2*g +: 2]),
            .hazard (opHaz[g])
         );
      end
   endgenerate

   always_comb begin
      luse      = deVld && (|opHaz);
      taken     = ex_taken && stg[0].vld;
      pc_we     = 1'b1;
      de_we     = 1'b1;
      pipe_we   = 1'b1;
      ex_bubble = !deVld;
      fwd_a_sel = opFwd[1:0];
      fwd_b_sel = opFwd[3:2];
      if (!CPU_RST_N) begin
         pc_we     = 1'b0;
         de_we     = 1'b0;
         pipe_we   = 1'b0;
         ex_bubble = 1'b1;
         fwd_a_sel = 2'd0;
         fwd_b_sel = 2'd0;
      end else if (mem_busy) begin
         pc_we     = 1'b0;
         de_we     = 1'b0;
         pipe_we   = 1'b0;
         ex_bubble = 1'b0;
      end else if (taken) begin
         // The DE instruction is wrong-path, so a pending load-use on it is moot
         ex_bubble = 1'b1;
      end else if (luse) begin
         pc_we     = 1'b0;
         de_we     = 1'b0;
         ex_bubble = 1'b1;
      end
   end

   always_comb begin
      newEx     = '0;
      newEx.vld = !ex_bubble;
      newEx.rd  = de_rd;
      newEx.rw  = de_reg_write;
      newEx.sel = de_wr_sel;
      stallInc  = !mem_busy && !taken && luse;
      flushInc  = !mem_busy && taken;
   end

   always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
      if (!CPU_RST_N) begin
         stg       <= '0;
         deVld     <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pipe_we) begin
            stg   <= {stg[1:0], newEx};
            deVld <= taken ? 1'b0 : (de_we ? 1'b1 : deVld);
         end
         if (stallInc && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
         if (flushInc && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed and randomized checks of otter_hazard_ctrl against an instruction-level
// reference model of the in-flight pipeline.
module tb_otter_hazard_ctrl;
   localparam int CW  = 4;
   localparam int MAX = (1 << CW) - 1;

   logic          CPU_CLK = 1'b0;
   logic          CPU_RST_N = 1'b0;
   logic [4:0]    de_rs1 = '0, de_rs2 = '0, de_rd = '0;
   logic          de_rs1_used = 1'b0, de_rs2_used = 1'b0, de_reg_write = 1'b0;
   logic [1:0]    de_wr_sel = '0;
   logic          ex_taken = 1'b0, mem_busy = 1'b0;
   logic          pc_we, de_we, ex_bubble, pipe_we;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic [CW-1:0] stall_cnt, flush_cnt;

   otter_hazard_ctrl #(.CNT_W(CW)) dut (
      .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
      .de_rs1(de_rs1), .de_rs2(de_rs2),
      .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
      .de_rd(de_rd), .de_reg_write(de_reg_write), .de_wr_sel(de_wr_sel),
      .ex_taken(ex_taken), .mem_busy(mem_busy),
      .pc_we(pc_we), .de_we(de_we), .ex_bubble(ex_bubble), .pipe_we(pipe_we),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 CPU_CLK = ~CPU_CLK;

   typedef struct {
      bit vld;
      int rd;
      bit rw;
      int sel;
   } minst_t;

   int     checks = 0, errors = 0;
   minst_t inflight[3];    // 0 = EX, 1 = MEM, 2 = WB
   bit     mDeVld, mLuse, mTaken;
   int     mStall, mFlush;
   int     ePc, eDe, ePipe, eBub, eFa, eFb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void modelReset();
      for (int i = 0; i < 3; i++) begin
         inflight[i].vld = 0; inflight[i].rd = 0; inflight[i].rw = 0; inflight[i].sel = 0;
      end
      mDeVld = 0; mStall = 0; mFlush = 0;
   endfunction

   // Youngest producer of the register decides: ALU results forward from EX/MEM,
   // anything else must wait until it sits in WB.
   function automatic void refOp(input int rs, input bit used, output int fwd, output bit haz);
      fwd = 0; haz = 0;
      if (!used || rs == 0) return;
      for (int s = 0; s < 3; s++)
         if (inflight[s].vld && inflight[s].rw && inflight[s].rd == rs) begin
            if (s == 2 || inflight[s].sel == 3) fwd = s + 1;
            else                                haz = 1;
            return;
         end
   endfunction

   function automatic void refEval();
      int  fa, fb;
      bit  ha, hb;
      refOp(int'(de_rs1), de_rs1_used, fa, ha);
      refOp(int'(de_rs2), de_rs2_used, fb, hb);
      mLuse  = mDeVld && (ha || hb);
      mTaken = ex_taken && inflight[0].vld;
      eFa = fa; eFb = fb;
      if (!CPU_RST_N) begin
         ePc = 0; eDe = 0; ePipe = 0; eBub = 1; eFa = 0; eFb = 0;
      end else if (mem_busy) begin
         ePc = 0; eDe = 0; ePipe = 0; eBub = 0;
      end else if (mTaken) begin
         ePc = 1; eDe = 1; ePipe = 1; eBub = 1;
      end else if (mLuse) begin
         ePc = 0; eDe = 0; ePipe = 1; eBub = 1;
      end else begin
         ePc = 1; eDe = 1; ePipe = 1; eBub = mDeVld ? 0 : 1;
      end
   endfunction

   task automatic setDe(input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input int sel);
      de_rs1 = rs1[4:0]; de_rs1_used = u1;
      de_rs2 = rs2[4:0]; de_rs2_used = u2;
      de_rd  = rd[4:0];  de_reg_write = rw; de_wr_sel = sel[1:0];
      #1;
   endtask

   // Compare every output with the model, advance the model, then cross one clock edge.
   task automatic tick();
      if (!CPU_RST_N) modelReset();
      refEval();
      chk("pc_we", pc_we, ePc);
      chk("de_we", de_we, eDe);
      chk("pipe_we", pipe_we, ePipe);
      chk("ex_bubble", ex_bubble, eBub);
      chk("fwd_a_sel", fwd_a_sel, eFa);
      chk("fwd_b_sel", fwd_b_sel, eFb);
      chk("stall_cnt", stall_cnt, mStall);
      chk("flush_cnt", flush_cnt, mFlush);
      if (CPU_RST_N && ePipe) begin
         if (mTaken)     mFlush = (mFlush < MAX) ? mFlush + 1 : MAX;
         else if (mLuse) mStall = (mStall < MAX) ? mStall + 1 : MAX;
         inflight[2] = inflight[1];
         inflight[1] = inflight[0];
         inflight[0].vld = !eBub;
         inflight[0].rd  = int'(de_rd);
         inflight[0].rw  = de_reg_write;
         inflight[0].sel = int'(de_wr_sel);
         mDeVld = mTaken ? 0 : (eDe ? 1 : mDeVld);
      end
      @(posedge CPU_CLK);
      #1;
   endtask

   task automatic doReset();
      CPU_RST_N = 1'b0; ex_taken = 1'b0; mem_busy = 1'b0;
      setDe(0, 0, 0, 0, 0, 0, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_flush", flush_cnt, 0);
      chk("rst_bubble", ex_bubble, 1);
      tick();
      CPU_RST_N = 1'b1;
      setDe(0, 0, 0, 0, 0, 0, 0);
      chk("rel_bubble1", ex_bubble, 1);
      chk("rel_pc_we", pc_we, 1);
      tick();
      setDe(0, 0, 0, 0, 0, 0, 0);
      chk("rel_bubble0", ex_bubble, 0);
      tick();
   endtask

   initial begin
      modelReset();
      doReset();

      // ALU result forwarded from EX, then from MEM
      setDe(0, 0, 0, 0, 5, 1, 3); tick();
      setDe(5, 1, 0, 0, 8, 1, 3);
      chk("fwd_ex", fwd_a_sel, 1); chk("fwd_ex_nostall", pc_we, 1); tick();
      setDe(5, 1, 0, 0, 9, 1, 3);
      chk("fwd_mem", fwd_a_sel, 2); tick();

      // Load-use: two stall cycles, then WB forwarding
      doReset();
      setDe(0, 0, 0, 0, 6, 1, 2); tick();
      setDe(6, 1, 6, 1, 7, 1, 3);
      chk("lu1_pc", pc_we, 0); chk("lu1_de", de_we, 0); chk("lu1_bub", ex_bubble, 1); tick();
      setDe(6, 1, 6, 1, 7, 1, 3);
      chk("lu2_pc", pc_we, 0); chk("lu2_bub", ex_bubble, 1); tick();
      setDe(6, 1, 6, 1, 7, 1, 3);
      chk("lu3_fa", fwd_a_sel, 3); chk("lu3_fb", fwd_b_sel, 3);
      chk("lu3_pc", pc_we, 1); chk("lu_stall_cnt", stall_cnt, 2); tick();

      // Taken branch overrides a load-use hazard in DE
      setDe(0, 0, 0, 0, 10, 1, 2); tick();
      ex_taken = 1'b1;
      setDe(10, 1, 0, 0, 11, 1, 3);
      chk("tk_pc", pc_we, 1); chk("tk_de", de_we, 1); chk("tk_bub", ex_bubble, 1); tick();
      ex_taken = 1'b0;
      setDe(10, 1, 10, 1, 12, 1, 3);
      chk("tk2_bub", ex_bubble, 1); chk("tk2_pc", pc_we, 1);
      chk("tk_flush_cnt", flush_cnt, 1); chk("tk_stall_cnt", stall_cnt, 2); tick();
      setDe(0, 0, 0, 0, 0, 0, 0);
      chk("tk3_bub", ex_bubble, 0); tick();

      // Memory freeze in the middle of a load-use stall
      doReset();
      setDe(0, 0, 0, 0, 6, 1, 2); tick();
      setDe(6, 1, 0, 0, 7, 1, 3);
      chk("mb_st1", pc_we, 0); tick();
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         setDe(6, 1, 0, 0, 7, 1, 3);
         chk("mb_pc", pc_we, 0); chk("mb_pipe", pipe_we, 0);
         chk("mb_bub", ex_bubble, 0); chk("mb_stall", stall_cnt, 1); tick();
      end
      mem_busy = 1'b0;
      setDe(6, 1, 0, 0, 7, 1, 3);
      chk("mb_st2", pc_we, 0); chk("mb_st2_bub", ex_bubble, 1); tick();
      setDe(6, 1, 0, 0, 7, 1, 3);
      chk("mb_fwd", fwd_a_sel, 3); chk("mb_done", pc_we, 1); chk("mb_stall_cnt", stall_cnt, 2); tick();

      // Writes to x0 never forward or stall
      setDe(0, 0, 0, 0, 0, 1, 2); tick();
      setDe(0, 1, 0, 1, 5, 1, 3);
      chk("x0_fa", fwd_a_sel, 0); chk("x0_fb", fwd_b_sel, 0); chk("x0_pc", pc_we, 1); tick();

      // Reset in the middle of a stall
      setDe(0, 0, 0, 0, 6, 1, 2); tick();
      setDe(6, 1, 0, 0, 7, 1, 3);
      chk("rs_stall", pc_we, 0); tick();
      CPU_RST_N = 1'b0;
      setDe(6, 1, 0, 0, 7, 1, 3);
      chk("rs_cnt", stall_cnt, 0); chk("rs_pc", pc_we, 0); chk("rs_bub", ex_bubble, 1); tick();
      CPU_RST_N = 1'b1;
      setDe(6, 1, 0, 0, 7, 1, 3);
      chk("rs_rel_bub", ex_bubble, 1); tick();
      setDe(6, 1, 0, 0, 7, 1, 3);
      chk("rs_nostall", pc_we, 1); chk("rs_fwd", fwd_a_sel, 0); tick();

      // Randomized traffic against the model, small register range for frequent hits
      for (int n = 0; n < 600; n++) begin
         CPU_RST_N = ($urandom_range(99) != 0);
         ex_taken  = ($urandom_range(5) == 0);
         mem_busy  = ($urandom_range(7) == 0);
         setDe($urandom_range(7), $urandom_range(1), $urandom_range(7), $urandom_range(1),
               $urandom_range(7), $urandom_range(1), $urandom_range(3));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/otter_hazard_ctrl.md
# otter_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipelined OTTER core (IF, DE, EX, MEM, WB). It keeps a shadow scoreboard of the instructions in flight and uses it to drive stage enables, bubble insertion and operand-forwarding selects.
- It resolves load-use and late-writer hazards by stalling IF/DE.
- It squashes wrong-path instructions after a taken branch or jump.
- It freezes the whole pipeline while data memory is busy.
- It keeps saturating stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters

Ports:
- CPU_CLK  in  1  core clock; all state updates on the rising edge
- CPU_RST_N  in  1  asynchronous, active-low reset
- de_rs1, de_rs2  in  5 each  source register addresses of the instruction in DE (IR[19:15], IR[24:20])
- de_rs1_used, de_rs2_used  in  1 each  the DE instruction reads that source
- de_rd  in  5  destination of the DE instruction (IR[11:7])
- de_reg_write  in  1  decoder regWrite for the DE instruction
- de_wr_sel  in  2  decoder rf_wr_sel: 0 = PC+4, 1 = CSR, 2 = load data, 3 = ALU result
- ex_taken  in  1  EX-stage pcSource != 0 (branch or jump redirecting the PC)
- mem_busy  in  1  data memory not ready; the pipeline must freeze
- pc_we  out  1  PC write enable
- de_we  out  1  IF/DE pipeline register enable
- ex_bubble  out  1  load a NOP into the EX register (clears regWrite, memWrite, memRead2 and the opcode)
- pipe_we  out  1  enable for the EX, MEM and WB pipeline registers
- fwd_a_sel, fwd_b_sel  out  2 each  DE operand source: 0 = regfile, 1 = EX aluRes, 2 = MEM aluRes, 3 = WB wd
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- Shadow state:
  - de_vld.
  - For each of EX, MEM and WB: vld, rd, rw (regWrite) and sel (wr_sel).
- Hit rules:
  - A source operand is "live" when it is used and its address is not 0.
  - A stage "hits" a live operand when that stage's vld and rw are set and its rd equals the operand address.
- Forwarding, evaluated independently per operand, youngest stage first:
  - EX hit with sel = 3: fwd = 1.
  - EX hit with sel ≠ 3: hazard.
  - Otherwise, MEM hit with sel = 3: fwd = 2.
  - MEM hit with sel ≠ 3: hazard.
  - Otherwise, WB hit: fwd = 3.
  - Otherwise: fwd = 0.
  - A non-live operand always gets fwd = 0.
- Event definitions:
  - luse = de_vld & (hazard on either operand).
  - taken = ex_taken & EX.vld.
- Outputs, in priority order:
  - mem_busy: pc_we = de_we = pipe_we = 0, ex_bubble = 0. All shadow state and counters hold.
  - taken: pc_we = de_we = pipe_we = 1, ex_bubble = 1. The DE instruction is killed and any luse is ignored.
  - luse: pc_we = de_we = 0, pipe_we = 1, ex_bubble = 1.
  - otherwise: pc_we = de_we = pipe_we = 1, and ex_bubble = !de_vld.
- Shadow update on a clock edge with pipe_we = 1:
  - WB ← MEM, MEM ← EX.
  - EX ← DE fields, with vld = !ex_bubble.
  - de_vld ← taken ? 0 : (de_we ? 1 : de_vld). The wrong-path fetch returns the following cycle and is bubbled because de_vld = 0.
- Counters (both saturate at all-ones):
  - stall_cnt += 1 on each cycle where luse & !taken & !mem_busy.
  - flush_cnt += 1 on each cycle where taken & !mem_busy.
- Reset:
  - While CPU_RST_N is low: all vld bits and de_vld = 0, counters = 0. Outputs are forced to pc_we = de_we = pipe_we = 0, ex_bubble = 1, fwd = 0.
  - After release: pc_we = de_we = pipe_we = 1 and ex_bubble = 1 until the first fetch is latched into DE.
  - Reset asserted mid-stall or mid-flush abandons that state immediately.

## Timing
- All outputs are combinational from the shadow state and the current-cycle inputs, with no added latency. Shadow state and counters update on the rising edge.
- A load followed immediately by a dependent instruction costs exactly 2 stall cycles (load in EX, then load in MEM). In the third cycle fwd = 3.
- A PC+4 or CSR writer (sel 0/1) followed by a dependent instruction is handled the same way: it forwards only from WB.
- A taken branch costs 2 bubbles: the DE instruction in the taken cycle, then the wrong-path fetch in the next cycle.
- WB forwarding covers the same-edge regfile write, so no write-through regfile is required.
- mem_busy may hold for any number of cycles. On release, the pipeline resumes with the state it had before the freeze.

## Test plan
- Reset, then release with no activity: pc_we = 1, de_we = 1, pipe_we = 1, ex_bubble = 1 for exactly 1 cycle, then 0. fwd = 0/0 and both counters = 0.
- add x5 in EX with sel = 3; DE reads rs1 = x5 -> fwd_a_sel = 1, no stall. The next cycle, with x5 in MEM and DE again reading x5 -> fwd_a_sel = 2.
- lw x6 then add x7,x6,x6 -> 2 cycles of pc_we = 0, de_we = 0, ex_bubble = 1. Third cycle: fwd_a_sel = fwd_b_sel = 3, no stall. stall_cnt = 2.
- ex_taken = 1 with valid EX while DE has a luse hazard -> no stall, ex_bubble = 1 for 2 consecutive cycles. flush_cnt = 1, stall_cnt unchanged.
- mem_busy held for 3 cycles in the middle of a load-use stall -> all enables 0, counters frozen. After release, the remaining stall cycle completes, for a total stall_cnt = 2.
- rd = x0 writer followed by a read of x0 -> fwd = 0, no stall. CPU_RST_N pulsed low mid-stall -> counters 0 and shadow cleared, no residual stall.
